// File: rtl/cpu_pkg.sv
// Shared constants, field helpers and the control bundle type for the 5-stage core.
// Covers instruction field positions, control bundle widths and bit indices, and the
// all-zero bubble control word.
package cpu_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned FUNCT_W    = 4;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned F3_LSB     = 12;
  localparam int unsigned F7_B30     = 30;

  localparam int unsigned CU_EX_W  = 3;
  localparam int unsigned CU_MEM_W = 2;
  localparam int unsigned CU_WB_W  = 2;

  // Bit indices inside the mem / wb control fields
  localparam int unsigned MEM_READ   = 0;
  localparam int unsigned MEM_WRITE  = 1;
  localparam int unsigned REG_WRITE  = 0;
  localparam int unsigned MEM_TO_REG = 1;

  typedef struct packed {
    logic [CU_EX_W-1:0]  ex;   // {alu_src, alu_op[1:0]}
    logic [CU_MEM_W-1:0] mem;  // [0]=mem_read [1]=mem_write
    logic [CU_WB_W-1:0]  wb;   // [0]=reg_write [1]=mem_to_reg
  } ctrl_t;

  // A bubble never writes the register file or memory
  localparam ctrl_t BUBBLE_CTRL = '0;

  function automatic logic [REG_ADDR_W-1:0] get_rs1(input logic [INSTR_W-1:0] instr);
    return instr[RS1_LSB +: REG_ADDR_W];
  endfunction

  function automatic logic [REG_ADDR_W-1:0] get_rs2(input logic [INSTR_W-1:0] instr);
    return instr[RS2_LSB +: REG_ADDR_W];
  endfunction

  function automatic logic [REG_ADDR_W-1:0] get_rd(input logic [INSTR_W-1:0] instr);
    return instr[RD_LSB +: REG_ADDR_W];
  endfunction

  // ALU control selector {instr[30], funct3}
  function automatic logic [FUNCT_W-1:0] get_funct(input logic [INSTR_W-1:0] instr);
    return {instr[F7_B30], instr[F3_LSB +: 3]};
  endfunction

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard compare between the EX slot and the ID instruction.
// Ports:
//   ex_valid_i, ex_mem_read_i, ex_rd_i  : state of the instruction currently in EX
//   id_valid_i, id_rs1_i, id_rs2_i      : source registers of the instruction in ID
//   load_use_o                          : EX is a load whose rd (non-x0) feeds ID
module load_use_detector
  import cpu_pkg::*;
(
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  output logic                  load_use_o
);

  // x0 is hardwired zero, so a load into x0 never creates a dependency
  assign load_use_o = ex_valid_i && ex_mem_read_i && (ex_rd_i != '0) && id_valid_i &&
                      ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures ID operands, immediate, control and register fields and presents them to EX
// one cycle later. Inserts a single bubble on load-use, squashes on flush, holds on
// external stall. Priority per edge: rst > flush > stall_ext > load_use > load.
// Ports:
//   clk, rst (sync, active-high)
//   id_*        : instruction, valid, pc, operands, immediate and control from ID
//   flush       : squash the ID instruction (branch taken)
//   stall_ext   : freeze front end and ID/EX
//   ex_*        : registered EX-side copies; id_ex_rs1_2 = {rs2,rs1} for forwarding
//   pc_write, if_id_write, load_use : combinational hazard outputs
// Optional: define ID_EX_PERF_CNT_EN to add saturating stall_cnt / flush_cnt outputs.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 64
`ifdef ID_EX_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W  = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INSTR_W-1:0]    id_instr,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [DATA_W-1:0]     id_rdata1,
  input  logic [DATA_W-1:0]     id_rdata2,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [CU_EX_W-1:0]    id_cu_ex,
  input  logic [CU_MEM_W-1:0]   id_cu_mem,
  input  logic [CU_WB_W-1:0]    id_cu_wb,
  input  logic                  flush,
  input  logic                  stall_ext,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [DATA_W-1:0]     ex_rdata1,
  output logic [DATA_W-1:0]     ex_rdata2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [CU_EX_W-1:0]    ex_cu_ex,
  output logic [CU_MEM_W-1:0]   ex_cu_mem,
  output logic [CU_WB_W-1:0]    ex_cu_wb,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [2*REG_ADDR_W-1:0] id_ex_rs1_2,
  output logic [FUNCT_W-1:0]    ex_funct,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  load_use
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);

  ctrl_t id_ctrl;
  ctrl_t ctrl_q, ctrl_d;
  logic                    valid_q, valid_d;
  logic [DATA_W-1:0]       pc_q, pc_d;
  logic [DATA_W-1:0]       rdata1_q, rdata1_d;
  logic [DATA_W-1:0]       rdata2_q, rdata2_d;
  logic [DATA_W-1:0]       imm_q, imm_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [2*REG_ADDR_W-1:0] rs12_q, rs12_d;
  logic [FUNCT_W-1:0]      funct_q, funct_d;
  logic                    lu;

  // Opcode and upper funct7 bits are decoded elsewhere
  logic unused_instr;
  assign unused_instr = ^{id_instr[31], id_instr[29:25], id_instr[6:0]};

  assign id_ctrl = {id_cu_ex, id_cu_mem, id_cu_wb};

  load_use_detector u_load_use_detector (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem[MEM_READ]),
    .ex_rd_i       (rd_q),
    .id_valid_i    (id_valid),
    .id_rs1_i      (get_rs1(id_instr)),
    .id_rs2_i      (get_rs2(id_instr)),
    .load_use_o    (lu)
  );

  // Front-end enables: flush overrides any stall, otherwise either stall source freezes
  assign load_use    = lu;
  assign pc_write    = rst || flush || !(stall_ext || lu);
  assign if_id_write = pc_write;

  // Next-state select for the ID/EX register bank
  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    imm_d    = imm_q;
    ctrl_d   = ctrl_q;
    rd_d     = rd_q;
    rs12_d   = rs12_q;
    funct_d  = funct_q;
    if (flush || (!stall_ext && lu)) begin
      valid_d  = 1'b0;
      pc_d     = '0;
      rdata1_d = '0;
      rdata2_d = '0;
      imm_d    = '0;
      ctrl_d   = BUBBLE_CTRL;
      rd_d     = '0;
      rs12_d   = '0;
      funct_d  = '0;
    end else if (!stall_ext) begin
      valid_d  = id_valid;
      pc_d     = id_pc;
      rdata1_d = id_rdata1;
      rdata2_d = id_rdata2;
      imm_d    = id_imm;
      ctrl_d   = id_valid ? id_ctrl : BUBBLE_CTRL;
      rd_d     = get_rd(id_instr);
      rs12_d   = {get_rs2(id_instr), get_rs1(id_instr)};
      funct_d  = get_funct(id_instr);
    end
  end

  // ID/EX register bank
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      ctrl_q   <= BUBBLE_CTRL;
      rd_q     <= '0;
      rs12_q   <= '0;
      funct_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      ctrl_q   <= ctrl_d;
      rd_q     <= rd_d;
      rs12_q   <= rs12_d;
      funct_q  <= funct_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_rdata1   = rdata1_q;
  assign ex_rdata2   = rdata2_q;
  assign ex_imm      = imm_q;
  assign ex_cu_ex    = ctrl_q.ex;
  assign ex_cu_mem   = ctrl_q.mem;
  assign ex_cu_wb    = ctrl_q.wb;
  assign ex_rd       = rd_q;
  assign id_ex_rs1_2 = rs12_q;
  assign ex_funct    = funct_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters; a load-use only counts when it actually inserts a bubble
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (lu && !flush && !stall_ext && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector scoreboard bench for id_ex_stage. The driver issues one vector per
// cycle and queues it with its hand-determined outcome; the monitor pops each vector,
// checks the combinational enables before the edge and the EX outputs after it.
module tb_id_ex_stage;

  localparam int K_LOAD   = 0;
  localparam int K_BUBBLE = 1;
  localparam int K_HOLD   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic        id_valid;
  logic [63:0] id_pc, id_rdata1, id_rdata2, id_imm;
  logic [2:0]  id_cu_ex;
  logic [1:0]  id_cu_mem, id_cu_wb;
  logic        flush, stall_ext;
  logic        ex_valid;
  logic [63:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
  logic [2:0]  ex_cu_ex;
  logic [1:0]  ex_cu_mem, ex_cu_wb;
  logic [4:0]  ex_rd;
  logic [9:0]  id_ex_rs1_2;
  logic [3:0]  ex_funct;
  logic        pc_write, if_id_write, load_use;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .id_pc(id_pc),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_cu_ex(id_cu_ex), .id_cu_mem(id_cu_mem), .id_cu_wb(id_cu_wb),
    .flush(flush), .stall_ext(stall_ext), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_cu_ex(ex_cu_ex), .ex_cu_mem(ex_cu_mem), .ex_cu_wb(ex_cu_wb), .ex_rd(ex_rd),
    .id_ex_rs1_2(id_ex_rs1_2), .ex_funct(ex_funct), .pc_write(pc_write),
    .if_id_write(if_id_write), .load_use(load_use)
`ifdef ID_EX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, stall, idv;
    logic [31:0] instr;
    logic [63:0] pc, r1, r2, imm;
    logic [2:0]  cex;
    logic [1:0]  cmem, cwb;
    int          kind;
    bit          chk_en;
    logic        pw, lu;
  } vec_t;

  vec_t q[$];
  int checks = 0;
  int errors = 0;
  int vec_n  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ins(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic b30,
                                      input logic [2:0] f3, input logic [6:0] op);
    return {1'b0, b30, 5'b0, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] add_i(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return ins(rd, rs1, rs2, 1'b0, 3'b000, 7'h33);
  endfunction

  function automatic logic [31:0] ld_i(input logic [4:0] rd, input logic [4:0] rs1);
    return ins(rd, rs1, 5'd0, 1'b0, 3'b011, 7'h03);
  endfunction

  // Apply one vector at the falling edge and queue it with its expected outcome
  task automatic issue(input logic r, input logic fl, input logic st, input logic idv,
                       input logic [31:0] instr, input logic [2:0] cex,
                       input logic [1:0] cmem, input logic [1:0] cwb, input int kind,
                       input bit chk_en, input logic pw, input logic lu);
    vec_t v;
    @(negedge clk);
    vec_n++;
    v.rst = r; v.flush = fl; v.stall = st; v.idv = idv; v.instr = instr;
    v.pc  = 64'h8000_0000 + 64'(vec_n * 4);
    v.r1  = {32'hA1A1_0000, 32'(vec_n)};
    v.r2  = {32'hB2B2_0000, 32'(vec_n)};
    v.imm = {32'hFFFF_FFFF, 32'(vec_n)};
    v.cex = cex; v.cmem = cmem; v.cwb = cwb; v.kind = kind;
    v.chk_en = chk_en; v.pw = pw; v.lu = lu;
    rst = r; flush = fl; stall_ext = st; id_valid = idv; id_instr = instr;
    id_pc = v.pc; id_rdata1 = v.r1; id_rdata2 = v.r2; id_imm = v.imm;
    id_cu_ex = cex; id_cu_mem = cmem; id_cu_wb = cwb;
    q.push_back(v);
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    vec_t v;
    logic        e_v;
    logic [63:0] e_pc, e_r1, e_r2, e_imm;
    logic [2:0]  e_cex;
    logic [1:0]  e_cmem, e_cwb;
    logic [4:0]  e_rd;
    logic [9:0]  e_rs12;
    logic [3:0]  e_fn;
    e_v = 0; e_pc = 0; e_r1 = 0; e_r2 = 0; e_imm = 0;
    e_cex = 0; e_cmem = 0; e_cwb = 0; e_rd = 0; e_rs12 = 0; e_fn = 0;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        v = q.pop_front();
        if (v.chk_en) begin
          chk("pc_write", 64'(pc_write), 64'(v.pw));
          chk("if_id_write", 64'(if_id_write), 64'(v.pw));
          chk("load_use", 64'(load_use), 64'(v.lu));
        end
        if (v.kind == K_BUBBLE) begin
          e_v = 0; e_pc = 0; e_r1 = 0; e_r2 = 0; e_imm = 0;
          e_cex = 0; e_cmem = 0; e_cwb = 0; e_rd = 0; e_rs12 = 0; e_fn = 0;
        end else if (v.kind == K_LOAD) begin
          e_v = v.idv; e_pc = v.pc; e_r1 = v.r1; e_r2 = v.r2; e_imm = v.imm;
          e_cex  = v.idv ? v.cex  : 3'b0;
          e_cmem = v.idv ? v.cmem : 2'b0;
          e_cwb  = v.idv ? v.cwb  : 2'b0;
          e_rd   = v.instr[11:7];
          e_rs12 = {v.instr[24:20], v.instr[19:15]};
          e_fn   = {v.instr[30], v.instr[14:12]};
        end
        @(posedge clk);
        #1;
        chk("ex_valid", 64'(ex_valid), 64'(e_v));
        chk("ex_pc", ex_pc, e_pc);
        chk("ex_rdata1", ex_rdata1, e_r1);
        chk("ex_rdata2", ex_rdata2, e_r2);
        chk("ex_imm", ex_imm, e_imm);
        chk("ex_cu_ex", 64'(ex_cu_ex), 64'(e_cex));
        chk("ex_cu_mem", 64'(ex_cu_mem), 64'(e_cmem));
        chk("ex_cu_wb", 64'(ex_cu_wb), 64'(e_cwb));
        chk("ex_rd", 64'(ex_rd), 64'(e_rd));
        chk("id_ex_rs1_2", 64'(id_ex_rs1_2), 64'(e_rs12));
        chk("ex_funct", 64'(ex_funct), 64'(e_fn));
      end
    end
  end

  // Driver: directed vectors with hand-determined outcomes
  initial begin : driver
    rst = 1; flush = 0; stall_ext = 0; id_valid = 0; id_instr = 0;
    id_pc = 0; id_rdata1 = 0; id_rdata2 = 0; id_imm = 0;
    id_cu_ex = 0; id_cu_mem = 0; id_cu_wb = 0;
    // reset, two cycles
    issue(1, 0, 0, 0, 32'h0, 3'b000, 2'b00, 2'b00, K_BUBBLE, 0, 1, 0);
    issue(1, 0, 0, 0, 32'h0, 3'b000, 2'b00, 2'b00, K_BUBBLE, 0, 1, 0);
    // idle after reset: enables high
    issue(0, 0, 0, 0, 32'h0, 3'b000, 2'b00, 2'b00, K_LOAD, 1, 1, 0);
    // add x3,x1,x2 pass-through
    issue(0, 0, 0, 1, add_i(5'd3, 5'd1, 5'd2), 3'b010, 2'b00, 2'b01, K_LOAD, 1, 1, 0);
    // ld x5 ; add x6,x5,x7 -> one bubble, then add enters EX
    issue(0, 0, 0, 1, ld_i(5'd5, 5'd3), 3'b100, 2'b01, 2'b11, K_LOAD, 1, 1, 0);
    issue(0, 0, 0, 1, add_i(5'd6, 5'd5, 5'd7), 3'b010, 2'b00, 2'b01, K_BUBBLE, 1, 0, 1);
    issue(0, 0, 0, 1, add_i(5'd6, 5'd5, 5'd7), 3'b010, 2'b00, 2'b01, K_LOAD, 1, 1, 0);
    // ld x0 ; use x0 -> no stall
    issue(0, 0, 0, 1, ld_i(5'd0, 5'd1), 3'b100, 2'b01, 2'b11, K_LOAD, 1, 1, 0);
    issue(0, 0, 0, 1, add_i(5'd1, 5'd0, 5'd0), 3'b010, 2'b00, 2'b01, K_LOAD, 1, 1, 0);
    // ld x5 ; add x10,x8,x9 -> no stall
    issue(0, 0, 0, 1, ld_i(5'd5, 5'd2), 3'b100, 2'b01, 2'b11, K_LOAD, 1, 1, 0);
    issue(0, 0, 0, 1, add_i(5'd10, 5'd8, 5'd9), 3'b010, 2'b00, 2'b01, K_LOAD, 1, 1, 0);
    // ld x5 ; flush with load-use on rs2 -> bubble, no stall
    issue(0, 0, 0, 1, ld_i(5'd5, 5'd2), 3'b100, 2'b01, 2'b11, K_LOAD, 1, 1, 0);
    issue(0, 1, 0, 1, add_i(5'd6, 5'd7, 5'd5), 3'b010, 2'b00, 2'b01, K_BUBBLE, 1, 1, 1);
    // second flush, no hazard
    issue(0, 1, 0, 1, ld_i(5'd5, 5'd2), 3'b100, 2'b01, 2'b11, K_BUBBLE, 1, 1, 0);
    // ld x5 then three external stall cycles with pending load-use, then one bubble
    issue(0, 0, 0, 1, ld_i(5'd5, 5'd2), 3'b100, 2'b01, 2'b11, K_LOAD, 1, 1, 0);
    for (int i = 0; i < 3; i++)
      issue(0, 0, 1, 1, add_i(5'd6, 5'd5, 5'd5), 3'b001, 2'b00, 2'b01, K_HOLD, 1, 0, 1);
    issue(0, 0, 0, 1, add_i(5'd6, 5'd5, 5'd5), 3'b001, 2'b00, 2'b01, K_BUBBLE, 1, 0, 1);
    issue(0, 0, 0, 1, add_i(5'd6, 5'd5, 5'd5), 3'b001, 2'b00, 2'b01, K_LOAD, 1, 1, 0);
    // third load-use bubble
    issue(0, 0, 0, 1, ld_i(5'd5, 5'd2), 3'b100, 2'b01, 2'b11, K_LOAD, 1, 1, 0);
    issue(0, 0, 0, 1, add_i(5'd6, 5'd0, 5'd5), 3'b010, 2'b00, 2'b01, K_BUBBLE, 1, 0, 1);
    issue(0, 0, 0, 1, ld_i(5'd5, 5'd2), 3'b100, 2'b01, 2'b11, K_LOAD, 1, 1, 0);
`ifdef ID_EX_PERF_CNT_EN
    #1;
    chk("stall_cnt", 64'(stall_cnt), 64'd3);
    chk("flush_cnt", 64'(flush_cnt), 64'd2);
`endif
    // stall pending, then reset mid-stall
    issue(0, 0, 1, 1, add_i(5'd6, 5'd5, 5'd0), 3'b010, 2'b00, 2'b01, K_HOLD, 1, 0, 1);
    issue(1, 0, 1, 1, add_i(5'd6, 5'd5, 5'd0), 3'b010, 2'b00, 2'b01, K_BUBBLE, 0, 1, 0);
    // invalid ID slot with nonzero control -> control forced to zero
    issue(0, 0, 0, 0, add_i(5'd9, 5'd5, 5'd5), 3'b111, 2'b11, 2'b11, K_LOAD, 1, 1, 0);
`ifdef ID_EX_PERF_CNT_EN
    chk("stall_cnt_rst", 64'(stall_cnt), 64'd0);
    chk("flush_cnt_rst", 64'(flush_cnt), 64'd0);
`endif
    // sub x3,x1,x2 : funct bit 30 set
    issue(0, 0, 0, 1, ins(5'd3, 5'd1, 5'd2, 1'b1, 3'b000, 7'h33), 3'b010, 2'b00, 2'b01,
          K_LOAD, 1, 1, 0);
    begin : drain
      int n;
      n = 0;
      while (q.size() != 0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL drain actual=%0d required=0 pending vectors", q.size());
      end
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
